// File: rtl/i2s_tx.sv
// Buffers 32-bit mono samples in a small FIFO and sends each one to both slots of a 64-bclk I2S frame.
// Build option I2S_TX_HOLD_ON_UNDERFLOW_EN: on underflow, repeat the last popped word instead of sending silence.

module i2s_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     i_push_vld,
  input  logic [WIDTH-1:0]         i_push_dat,
  output logic                     o_push_rdy,
  input  logic                     i_pop_vld,
  output logic                     o_pop_rdy,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = i_pop_vld && (r_count != '0);
  assign o_push_rdy = !w_full || w_pop;
  assign w_push     = i_push_vld && o_push_rdy;
  assign o_pop_rdy  = (r_count != '0);
  assign o_pop_dat  = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

module i2s_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [31:0]                   audio_in,
  input  logic                          audio_valid_in,
  output logic                          bclk_out,
  output logic                          lrclk_out,
  output logic                          sdata_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          overflow_out,
  output logic                          underflow_out
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] r_div_cnt;
  logic          r_bclk;
  logic [5:0]    r_f;
  logic [31:0]   r_frame_word;
  logic          r_lrclk;
  logic          r_sdata;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_div_wrap;
  logic          w_fall_tick;
  logic [5:0]    w_f_next;
  logic          w_frame_start;
  logic [4:0]    w_bit_idx;
  logic          w_push_rdy;
  logic          w_fifo_nonempty;
  logic [31:0]   w_fifo_dat;
  logic          w_pop_ok;
  logic [31:0]   w_underflow_word;

  assign w_div_wrap    = (r_div_cnt == DW'(CLK_DIV - 1));
  assign w_fall_tick   = w_div_wrap && r_bclk;
  assign w_f_next      = r_f + 6'd1;
  assign w_frame_start = w_fall_tick && (r_f == 6'd63);
  assign w_pop_ok      = w_frame_start && w_fifo_nonempty;

  // One-bclk I2S delay: entering f, send bit (32-f) mod 32. At f=0 that is bit 0 of the word
  // still held, because frame_word reloads on the same edge.
  assign w_bit_idx = 5'd0 - w_f_next[4:0];

  i2s_tx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_push_vld (audio_valid_in),
    .i_push_dat (audio_in),
    .o_push_rdy (w_push_rdy),
    .i_pop_vld  (w_frame_start),
    .o_pop_rdy  (w_fifo_nonempty),
    .o_pop_dat  (w_fifo_dat),
    .o_count    (fifo_count_out)
  );

`ifdef I2S_TX_HOLD_ON_UNDERFLOW_EN
  logic [31:0] r_last_word;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_last_word <= '0;
    end else if (w_pop_ok) begin
      r_last_word <= w_fifo_dat;
    end
  end

  assign w_underflow_word = r_last_word;
`else
  assign w_underflow_word = '0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DW'(1);
      if (w_div_wrap) begin
        r_bclk <= ~r_bclk;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_f          <= 6'd63;
      r_frame_word <= '0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
    end else if (w_fall_tick) begin
      r_f     <= w_f_next;
      r_lrclk <= w_f_next[5];
      r_sdata <= r_frame_word[w_bit_idx];
      if (w_frame_start) begin
        r_frame_word <= w_fifo_nonempty ? w_fifo_dat : w_underflow_word;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= audio_valid_in && !w_push_rdy;
      r_underflow <= w_frame_start && !w_fifo_nonempty;
    end
  end

  assign bclk_out      = r_bclk;
  assign lrclk_out     = r_lrclk;
  assign sdata_out     = r_sdata;
  assign overflow_out  = r_overflow;
  assign underflow_out = r_underflow;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a per-frame vector table plus hand sequences; a frame scoreboard is checked
// against the captured serial data.
module tb_i2s_tx;

  localparam int CLK_DIV     = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int FRAME_CYC   = 128 * CLK_DIV;
  localparam int FIRST_START = 2 * CLK_DIV;
  localparam int NVEC        = 9;
`ifdef I2S_TX_HOLD_ON_UNDERFLOW_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b0;
  logic [31:0]                 audio_in = '0;
  logic                        audio_valid_in = 1'b0;
  logic                        bclk_out;
  logic                        lrclk_out;
  logic                        sdata_out;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_out;
  logic                        overflow_out;
  logic                        underflow_out;

  i2s_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .audio_in       (audio_in),
    .audio_valid_in (audio_valid_in),
    .bclk_out       (bclk_out),
    .lrclk_out      (lrclk_out),
    .sdata_out      (sdata_out),
    .fifo_count_out (fifo_count_out),
    .overflow_out   (overflow_out),
    .underflow_out  (underflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] word;
    logic        uf;
  } exp_t;

  typedef struct {
    logic        push;
    logic [31:0] word;
    logic [31:0] exp_word;
    logic        exp_uf;
    logic [3:0]  exp_cnt;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NVEC];

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_add(input logic [31:0] w, input logic uf);
    exp_t e;
    e.word = w;
    e.uf   = uf;
    sb.push_back(e);
  endtask

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  // Drive a write so it is sampled on clock edge c; returns at the negedge after that edge.
  task automatic push_at(input int c, input logic [31:0] w);
    while (cyc < c - 1) @(negedge clk_in);
    audio_in       = w;
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
  endtask

  // Serial capture: frame bits are compared once the trailing f=0 bit arrives.
  int          f_mon;
  int          frame_idx;
  int          n_frames = 0;
  int          ovf_pulses = 0;
  logic        prev_bclk;
  logic        first_rise;
  logic        have_cur;
  logic        cur_uf;
  logic [31:0] cur_exp;
  logic [31:0] cap_l;
  logic [31:0] cap_r;

  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      f_mon      = 63;
      frame_idx  = 0;
      prev_bclk  = 1'b0;
      first_rise = 1'b1;
      have_cur   = 1'b0;
    end else begin
      if (overflow_out) ovf_pulses++;
      if (!prev_bclk && bclk_out && first_rise) begin
        check("first_bclk_rise_cycle", cyc, CLK_DIV);
        first_rise = 1'b0;
      end
      if (prev_bclk && !bclk_out) begin
        f_mon = (f_mon + 1) % 64;
        if (f_mon == 0) begin
          if (have_cur) begin
            cap_r[0] = sdata_out;
            check("left_slot", cap_l, cur_exp);
            check("right_slot", cap_r, cur_exp);
            n_frames++;
          end
          check("frame_start_cycle", cyc, FIRST_START + FRAME_CYC * frame_idx);
          frame_idx++;
          have_cur = (sb.size() > 0);
          if (have_cur) begin
            e       = sb.pop_front();
            cur_exp = e.word;
            cur_uf  = e.uf;
            check("underflow_at_start", underflow_out, cur_uf);
          end
        end else begin
          if (f_mon <= 32) cap_l[32 - f_mon] = sdata_out;
          else             cap_r[64 - f_mon] = sdata_out;
          check("underflow_idle", underflow_out, 0);
        end
        check("lrclk", lrclk_out, f_mon >= 32);
      end else begin
        check("underflow_idle", underflow_out, 0);
      end
      prev_bclk = bclk_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int s;
    vecs[0] = '{1'b1, 32'h8000_0001, 32'h8000_0001, 1'b0, 4'd1};
    vecs[1] = '{1'b1, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 4'd1};
    vecs[2] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 4'd1};
    vecs[3] = '{1'b0, 32'h0,         HOLD ? 32'h1234_5678 : 32'h0, 1'b1, 4'd0};
    vecs[4] = '{1'b0, 32'h0,         HOLD ? 32'h1234_5678 : 32'h0, 1'b1, 4'd0};
    vecs[5] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 4'd1};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'd1};
    vecs[7] = '{1'b0, 32'h0,         32'h0,         1'b1, 4'd0};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd1};

    // Reset held while strobing writes: everything stays at zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      audio_valid_in = 1'b1;
      audio_in       = $urandom;
      check("reset_outputs",
            32'({bclk_out, lrclk_out, sdata_out, overflow_out, underflow_out, fifo_count_out}), 0);
    end
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    rst_in         = 1'b1;

    // One record per frame: a write lands before frame start i and shows up as frame i.
    for (int i = 0; i < NVEC; i++) begin
      t = (i == 0) ? 2 : FIRST_START + FRAME_CYC * (i - 1) + 100;
      sb_add(vecs[i].exp_word, vecs[i].exp_uf);
      if (vecs[i].push) push_at(t, vecs[i].word);
      else              wait_until(t);
      check("vec_fifo_count", 32'(fifo_count_out), 32'(vecs[i].exp_cnt));
    end

    // Nine back-to-back writes into an empty FIFO; the ninth is dropped.
    s = FIRST_START + FRAME_CYC * 8;
    wait_until(s + 10);
    for (int j = 0; j < 9; j++) begin
      audio_in       = 32'hC0DE_0000 + 32'(j);
      audio_valid_in = 1'b1;
      if (j < 8) sb_add(32'hC0DE_0000 + 32'(j), 1'b0);
      @(negedge clk_in);
      check("overflow_pulse", overflow_out, (j == 8));
    end
    audio_valid_in = 1'b0;
    check("full_count", 32'(fifo_count_out), FIFO_DEPTH);
    @(negedge clk_in);
    check("overflow_one_cycle", overflow_out, 0);

    // Write on the frame-start edge of a full FIFO: the pop makes room.
    push_at(s + FRAME_CYC, 32'h5A5A_A5A5);
    check("simul_count", 32'(fifo_count_out), FIFO_DEPTH);
    check("simul_no_overflow", overflow_out, 0);
    sb_add(32'h5A5A_A5A5, 1'b0);
    sb_add(HOLD ? 32'h5A5A_A5A5 : 32'h0, 1'b1);
    sb_add(HOLD ? 32'h5A5A_A5A5 : 32'h0, 1'b1);
    wait_until(FIRST_START + FRAME_CYC * 20 + 2);

    // Reset asserted at f=20 with one word queued.
    t = FIRST_START + FRAME_CYC * 20;
    push_at(t + 6, 32'hFFFF_FFFF);
    wait_until(t + 20 * 2 * CLK_DIV + 3);
    check("pre_reset_count", 32'(fifo_count_out), 1);
    check("pre_reset_lrclk", lrclk_out, 0);
    #2;
    rst_in = 1'b0;
    sb.delete();
    #1;
    check("async_reset_outputs",
          32'({bclk_out, lrclk_out, sdata_out, overflow_out, underflow_out, fifo_count_out}), 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    sb_add(32'h0, 1'b1);
    push_at(100, 32'hC0FF_EE11);
    sb_add(32'hC0FF_EE11, 1'b0);
    wait_until(FIRST_START + FRAME_CYC * 2 + 2);

    check("frames_compared", n_frames, 22);
    check("overflow_pulse_total", ovf_pulses, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
